// File: rtl/syst_apb_pkg.sv
// syst_apb_pkg: shared state encoding, request type and slave register map
// for the systolic-array APB requester.
package syst_apb_pkg;
  localparam logic [31:0] SYST_ADR_WDATA = 32'h0;
  localparam logic [31:0] SYST_ADR_RDATA = 32'h4;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;
  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } state_e;
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } syst_req_t;
endpackage

// File: rtl/syst_apb_wdog.sv
// syst_apb_wdog: ACCESS-phase watchdog; expire_o flags the TIMEOUT-th
// consecutive ACCESS cycle without p_ready.
module syst_apb_wdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = $clog2(TIMEOUT) + 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expire_o = cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/syst_apb_master.sv
// syst_apb_master: valid/ready command stream to single APB3 transfers.
// Define SYST_APB_MST_TIMEOUT_EN to abort ACCESS phases after TIMEOUT cycles.
module syst_apb_master
  import syst_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              p_clk_i,
  input  logic              p_rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_adr_i,
  input  logic [DATA_W-1:0] req_dat_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic              rsp_err_o,
  output logic              p_sel_o,
  output logic              p_enable_o,
  output logic              p_we_o,
  output logic [ADDR_W-1:0] p_adr_o,
  output logic [DATA_W-1:0] p_dat_o,
  input  logic [DATA_W-1:0] p_dat_i,
  input  logic              p_ready_i,
  input  logic              p_slverr_i
);
  state_e state_q, state_d;
  logic we_q, we_d, rsp_err_q, rsp_err_d, accept, done, expire;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d, rsp_dat_q, rsp_dat_d;
  assign accept = req_valid_i && req_ready_o;
  assign done = state_q == ACCESS && (p_ready_i || expire);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = req_valid_i ? SETUP : IDLE;
      SETUP:  state_d = ACCESS;
      ACCESS: state_d = done ? RESP : ACCESS;
      RESP:   state_d = rsp_ready_i ? IDLE : RESP;
    endcase
  end
  // write data is zeroed at capture so reads never present stale data on the bus
  always_comb begin
    we_d = accept ? req_we_i : we_q;
    adr_d = accept ? req_adr_i : adr_q;
    dat_d = accept ? (req_we_i ? req_dat_i : '0) : dat_q;
    rsp_dat_d = !done ? rsp_dat_q : (p_ready_i && !we_q) ? p_dat_i : '0;
    rsp_err_d = !done ? rsp_err_q : p_ready_i ? p_slverr_i : 1'b1;
  end
  always_ff @(posedge p_clk_i or negedge p_rst_ni) begin
    if (!p_rst_ni) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`ifdef SYST_APB_MST_TIMEOUT_EN
  syst_apb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i   (p_clk_i),
    .rst_ni  (p_rst_ni),
    .clr_i   (state_q == SETUP),
    .en_i    (state_q == ACCESS && !p_ready_i),
    .expire_o(expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT != 0;
  assign expire = 1'b0;
`endif
  // bus fields are gated by select so they read 0 outside a transfer and during reset
  assign req_ready_o = p_rst_ni && state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign p_sel_o     = state_q == SETUP || state_q == ACCESS;
  assign p_enable_o  = state_q == ACCESS;
  assign p_we_o      = p_sel_o && we_q;
  assign p_adr_o     = p_sel_o ? adr_q : '0;
  assign p_dat_o     = p_sel_o ? dat_q : '0;
endmodule

// File: tb/tb_syst_apb_master.sv
// tb_syst_apb_master: scoreboard bench for syst_apb_master driving a
// behavioural systolic APB slave with programmable ready latency.
module tb_syst_apb_master;
  import syst_apb_pkg::*;
  localparam int TMO = 8;
  typedef struct packed { logic [31:0] dat; logic err; } rsp_t;
  typedef struct { int lat; logic [31:0] rdata; logic err; } slv_t;
  logic p_clk_i = 0, p_rst_ni = 0, req_valid_i = 0, req_we_i = 0, rsp_ready_i = 1;
  logic [31:0] req_adr_i = 0, req_dat_i = 0, p_dat_i = 0;
  logic p_ready_i = 0, p_slverr_i = 0;
  logic req_ready_o, rsp_valid_o, rsp_err_o, p_sel_o, p_enable_o, p_we_o;
  logic [31:0] rsp_dat_o, p_adr_o, p_dat_o;
  rsp_t rsp_q[$];
  syst_req_t apb_q[$];
  slv_t cfg_q[$];
  syst_req_t su;
  int n_cmp = 0, n_bad = 0, acc_n = 0, idle_n = 0;
  logic stray = 0, in_acc = 0, prev_setup = 0, seen = 0;

  always #5 p_clk_i = ~p_clk_i;

  syst_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .p_clk_i(p_clk_i), .p_rst_ni(p_rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .p_sel_o(p_sel_o), .p_enable_o(p_enable_o), .p_we_o(p_we_o), .p_adr_o(p_adr_o),
    .p_dat_o(p_dat_o), .p_dat_i(p_dat_i), .p_ready_i(p_ready_i), .p_slverr_i(p_slverr_i)
  );

  function automatic void chk(string name, logic [71:0] act, logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // slave: single-cycle p_ready on ACCESS cycle lat+1 (lat<0 never answers)
  always @(posedge p_clk_i or negedge p_rst_ni) begin
    if (!p_rst_ni) begin
      cfg_q.delete();
      acc_n = 0;
      in_acc = 0;
      p_ready_i = 0;
      p_slverr_i = 0;
    end else begin
      #1;
      if (p_sel_o && p_enable_o) begin
        in_acc = 1;
        acc_n++;
        p_ready_i = cfg_q.size() != 0 && cfg_q[0].lat >= 0 && acc_n == cfg_q[0].lat + 1;
        p_dat_i = p_ready_i ? cfg_q[0].rdata : 32'h5A5A5A5A;
        p_slverr_i = p_ready_i && cfg_q[0].err;
      end else begin
        if (in_acc && cfg_q.size() != 0) begin
          chk("access_len", 72'(acc_n), 72'(cfg_q[0].lat >= 0 ? cfg_q[0].lat + 1 : TMO));
          void'(cfg_q.pop_front());
        end
        in_acc = 0;
        acc_n = 0;
        p_ready_i = stray;
        p_slverr_i = 0;
        p_dat_i = 32'hA5A5A5A5;
      end
    end
  end

  // response scoreboard and APB protocol monitor
  always @(negedge p_clk_i) begin
    if (p_rst_ni) begin
      if (rsp_valid_o) begin
        if (rsp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got dat %h err %b, want no response at %0t", rsp_dat_o, rsp_err_o, $time);
        end else begin
          chk("rsp_dat", 72'(rsp_dat_o), 72'(rsp_q[0].dat));
          chk("rsp_err", 72'(rsp_err_o), 72'(rsp_q[0].err));
          if (rsp_ready_i) void'(rsp_q.pop_front());
        end
      end
      if (p_sel_o && !p_enable_o) begin
        if (seen) chk("idle_gap_ge2", 72'(idle_n >= 2), 72'(1));
        if (apb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_setup: got adr %h, want no transfer at %0t", p_adr_o, $time);
        end else begin
          su = apb_q.pop_front();
          chk("setup_fields", 72'({p_we_o, p_adr_o, p_dat_o}), 72'(su));
        end
        prev_setup = 1;
        seen = 1;
      end else begin
        if (prev_setup) chk("setup_one_cycle", 72'(p_sel_o && p_enable_o), 72'(1));
        prev_setup = 0;
      end
      if (p_sel_o && p_enable_o) chk("access_stable", 72'({p_we_o, p_adr_o, p_dat_o}), 72'(su));
      idle_n = p_sel_o ? 0 : idle_n + 1;
    end else begin
      seen = 0;
      prev_setup = 0;
      idle_n = 0;
    end
  end

  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat, input int lat,
                      input logic [31:0] rdata, input logic err, input logic [31:0] edat,
                      input logic eerr, input bit push);
    bit acc = 0;
    slv_t c;
    syst_req_t r;
    rsp_t e;
    c.lat = lat;
    c.rdata = rdata;
    c.err = err;
    cfg_q.push_back(c);
    r.we = we;
    r.adr = adr;
    r.dat = we ? dat : 32'h0;
    apb_q.push_back(r);
    e.dat = edat;
    e.err = eerr;
    if (push) rsp_q.push_back(e);
    req_we_i = we;
    req_adr_i = adr;
    req_dat_i = dat;
    req_valid_i = 1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge p_clk_i);
      acc = req_ready_o;
      @(posedge p_clk_i);
      #1;
    end
    req_valid_i = 0;
    chk("req_accepted", 72'(acc), 72'(1));
  endtask

  task automatic drain();
    int i = 0;
    while ((rsp_q.size() != 0 || !req_ready_o) && i < 200) begin
      @(posedge p_clk_i);
      #1;
      i++;
    end
    chk("drain", 72'(rsp_q.size()), 72'(0));
  endtask

  initial begin
    bit got = 0;
    repeat (3) @(posedge p_clk_i);
    #1;
    chk("rst_ctl", 72'({req_ready_o, rsp_valid_o, rsp_err_o, p_sel_o, p_enable_o, p_we_o}), 72'(0));
    chk("rst_data", 72'({p_adr_o, p_dat_o}), 72'(0));
    p_rst_ni = 1;
    @(negedge p_clk_i);
    chk("idle_ctl", 72'({req_ready_o, rsp_valid_o, rsp_err_o, p_sel_o, p_enable_o, p_we_o}), 72'(6'b100000));
    chk("idle_rsp_dat", 72'(rsp_dat_o), 72'(0));
    @(posedge p_clk_i);
    #1;
    send(1, SYST_ADR_WDATA, 32'hDEADBEEF, 4, 32'h0, 0, 32'h0, 0, 1);
    drain();
    rsp_ready_i = 0;
    send(0, SYST_ADR_RDATA, 32'hCAFEF00D, 2, 32'h12345678, 0, 32'h12345678, 0, 1);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge p_clk_i);
      got = rsp_valid_o;
    end
    chk("read_rsp_seen", 72'(got), 72'(1));
    repeat (5) @(posedge p_clk_i);
    #1;
    rsp_ready_i = 1;
    drain();
    send(1, SYST_ADR_WDATA, 32'h00000001, 0, 32'h0, 0, 32'h0, 0, 1);
    send(1, SYST_ADR_WDATA, 32'h00000002, 1, 32'h0, 0, 32'h0, 0, 1);
    send(1, SYST_ADR_WDATA, 32'h00000003, 0, 32'h0, 0, 32'h0, 0, 1);
    drain();
    send(1, SYST_ADR_WDATA, 32'h00000055, 1, 32'h0, 1, 32'h0, 1, 1);
    send(0, SYST_ADR_RDATA, 32'h0, 0, 32'h000000AA, 1, 32'h000000AA, 1, 1);
    drain();
    stray = 1;
    repeat (4) @(posedge p_clk_i);
    stray = 0;
    repeat (2) @(posedge p_clk_i);
    @(negedge p_clk_i);
    chk("stray_ready_ignored", 72'({rsp_valid_o, p_sel_o, req_ready_o}), 72'(3'b001));
    @(posedge p_clk_i);
    #1;
    send(0, SYST_ADR_RDATA, 32'h0, TMO - 1, 32'h600DF00D, 0, 32'h600DF00D, 0, 1);
    drain();
`ifdef SYST_APB_MST_TIMEOUT_EN
    send(0, SYST_ADR_RDATA, 32'h0, -1, 32'h77777777, 0, 32'h0, 1, 1);
    drain();
`endif
    send(1, SYST_ADR_WDATA, 32'h11112222, 20, 32'h0, 0, 32'h0, 0, 0);
    repeat (3) @(posedge p_clk_i);
    #3;
    p_rst_ni = 0;
    #1;
    chk("async_rst_bus", 72'({p_sel_o, p_enable_o, rsp_valid_o, p_adr_o}), 72'(0));
    repeat (2) @(posedge p_clk_i);
    #1;
    p_rst_ni = 1;
    repeat (5) @(posedge p_clk_i);
    #1;
    send(0, SYST_ADR_RDATA, 32'h0, 1, 32'h31415926, 0, 32'h31415926, 0, 1);
    drain();
    repeat (3) @(posedge p_clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
